// File: rtl/cache_control_core.sv
// Control FSM for one set-associative cache datapath: sequences hit handling,
// victim write-back and line fill, and keeps saturating hit/miss/write-back counters.
module cache_control_core #(
    parameter int s_cnt = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upstream_read,
    input  logic             upstream_write,
    output logic             upstream_resp,
    output logic             downstream_read,
    output logic             downstream_write,
    input  logic             downstream_resp,
    input  logic             hit,
    input  logic             valid,
    input  logic             dirty,
    output logic             cache_read,
    output logic             cache_load_en,
    output logic             downstream_address_sel,
    output logic             ld_wb,
    output logic             ld_LRU,
    output logic             new_dirty,
    input  logic             counter_clear,
    output logic [s_cnt-1:0] hit_count,
    output logic [s_cnt-1:0] miss_count,
    output logic [s_cnt-1:0] wb_count
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FILL,
        REREAD
    } state_t;

    localparam logic [s_cnt-1:0] CNT_ONE = {{(s_cnt-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic             r_retry;
    logic [s_cnt-1:0] r_hit_count;
    logic [s_cnt-1:0] r_miss_count;
    logic [s_cnt-1:0] r_wb_count;
    logic             w_hit_inc;
    logic             w_miss_inc;
    logic             w_wb_inc;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output and w_next gets a default first, so no path can infer a latch.
    always_comb begin
        w_next                 = r_state;
        upstream_resp          = 1'b0;
        downstream_read        = 1'b0;
        downstream_write       = 1'b0;
        cache_read             = 1'b0;
        cache_load_en          = 1'b0;
        downstream_address_sel = 1'b0;
        ld_wb                  = 1'b0;
        ld_LRU                 = 1'b0;
        new_dirty              = 1'b0;
        case (r_state)
            IDLE: begin
                cache_read = 1'b1;
                if (upstream_read || upstream_write) w_next = CHECK;
            end
            CHECK: begin
                cache_read = 1'b1;
                if (hit) begin
                    upstream_resp = 1'b1;
                    ld_LRU        = 1'b1;
                    cache_load_en = upstream_write;
                    new_dirty     = upstream_write;
                    w_next        = IDLE;
                end else if (valid && dirty) begin
                    ld_wb  = 1'b1;
                    w_next = WRITEBACK;
                end else begin
                    w_next = FILL;
                end
            end
            WRITEBACK: begin
                downstream_address_sel = 1'b1;
                downstream_write       = 1'b1;
                if (downstream_resp) w_next = FILL;
            end
            FILL: begin
                downstream_read = 1'b1;
                if (downstream_resp) begin
                    cache_load_en = 1'b1;
                    w_next        = REREAD;
                end
            end
            REREAD: begin
                cache_read = 1'b1;
                w_next     = CHECK;
            end
            default: w_next = IDLE;
        endcase
    end

    // The re-probe after a fill is not a new access, so it must not be counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retry <= 1'b0;
        end else if (r_state == FILL && downstream_resp) begin
            r_retry <= 1'b1;
        end else if (r_state == CHECK) begin
            r_retry <= 1'b0;
        end
    end

    assign w_hit_inc  = (r_state == CHECK) && !r_retry && hit;
    assign w_miss_inc = (r_state == CHECK) && !r_retry && !hit;
    assign w_wb_inc   = (r_state == WRITEBACK) && downstream_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else if (counter_clear) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            if (w_hit_inc && r_hit_count != '1)   r_hit_count  <= r_hit_count + CNT_ONE;
            if (w_miss_inc && r_miss_count != '1) r_miss_count <= r_miss_count + CNT_ONE;
            if (w_wb_inc && r_wb_count != '1)     r_wb_count   <= r_wb_count + CNT_ONE;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
    assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_cache_control_core.sv
// Bench for cache_control_core: a 4-way single-set datapath stub feeds hit/valid/dirty,
// and per-request expected output traces are built from the protocol rules and checked every cycle.
module tb_cache_control_core;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    localparam int E_CR  = 8;
    localparam int E_LE  = 7;
    localparam int E_SEL = 6;
    localparam int E_WB  = 5;
    localparam int E_LRU = 4;
    localparam int E_ND  = 3;
    localparam int E_UR  = 2;
    localparam int E_DR  = 1;
    localparam int E_DW  = 0;

    typedef struct packed {
        logic        ur;
        logic        uw;
        logic        dresp;
        logic        clr;
        logic        rst;
        logic [15:0] tag;
        logic [8:0]  exp;
        logic        ih;
        logic        im;
        logic        iw;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          upstream_read = 1'b0;
    logic          upstream_write = 1'b0;
    logic          upstream_resp;
    logic          downstream_read;
    logic          downstream_write;
    logic          downstream_resp = 1'b0;
    logic          cache_read;
    logic          cache_load_en;
    logic          downstream_address_sel;
    logic          ld_wb;
    logic          ld_LRU;
    logic          new_dirty;
    logic          counter_clear = 1'b0;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;
    logic [CW-1:0] wb_count;
    logic [15:0]   req_tag = '0;

    int checks = 0;
    int errors = 0;
    int m_hit  = 0;
    int m_miss = 0;
    int m_wb   = 0;
    int cyc_n  = 0;
    vec_t exp_q[$];
    vec_t cv;

    // Datapath stub: one set of four ways with timestamp LRU.
    logic [15:0] dp_tag[4]   = '{16'h0, 16'h0, 16'h0, 16'h0};
    logic        dp_vld[4]   = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic        dp_drt[4]   = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          dp_stamp[4] = '{0, 0, 0, 0};
    int          dp_time     = 0;
    logic        dp_hit;
    int          dp_hw;
    int          dp_vic;
    logic        dp_valid;
    logic        dp_dirty;

    always_comb begin
        int vsel;
        dp_hit = 1'b0;
        dp_hw  = 0;
        for (int i = 0; i < 4; i++) begin
            if (dp_vld[i] && dp_tag[i] == req_tag) begin
                dp_hit = 1'b1;
                dp_hw  = i;
            end
        end
        vsel = 0;
        for (int i = 1; i < 4; i++) begin
            if (dp_stamp[i] < dp_stamp[vsel]) vsel = i;
        end
        dp_vic   = vsel;
        dp_valid = dp_vld[vsel];
        dp_dirty = dp_drt[vsel];
    end

    always @(posedge clk) begin
        if (cache_load_en) begin
            int w;
            w = dp_hit ? dp_hw : dp_vic;
            dp_tag[w]   <= req_tag;
            dp_vld[w]   <= 1'b1;
            dp_drt[w]   <= new_dirty;
            dp_stamp[w] <= dp_time + 1;
        end else if (ld_LRU && dp_hit) begin
            dp_stamp[dp_hw] <= dp_time + 1;
        end
        dp_time <= dp_time + 1;
    end

    cache_control_core #(.s_cnt(CW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .upstream_read          (upstream_read),
        .upstream_write         (upstream_write),
        .upstream_resp          (upstream_resp),
        .downstream_read        (downstream_read),
        .downstream_write       (downstream_write),
        .downstream_resp        (downstream_resp),
        .hit                    (dp_hit),
        .valid                  (dp_valid),
        .dirty                  (dp_dirty),
        .cache_read             (cache_read),
        .cache_load_en          (cache_load_en),
        .downstream_address_sel (downstream_address_sel),
        .ld_wb                  (ld_wb),
        .ld_LRU                 (ld_LRU),
        .new_dirty              (new_dirty),
        .counter_clear          (counter_clear),
        .hit_count              (hit_count),
        .miss_count             (miss_count),
        .wb_count               (wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One compare process: outputs and counters against the trace and counter model.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cv = exp_q.pop_front();
            cyc_n++;
            if (cv.rst) begin
                m_hit  = 0;
                m_miss = 0;
                m_wb   = 0;
            end
            check($sformatf("outs@%0d", cyc_n),
                  32'({cache_read, cache_load_en, downstream_address_sel, ld_wb, ld_LRU,
                       new_dirty, upstream_resp, downstream_read, downstream_write}),
                  32'(cv.exp));
            check($sformatf("hit_count@%0d", cyc_n), 32'(hit_count), m_hit);
            check($sformatf("miss_count@%0d", cyc_n), 32'(miss_count), m_miss);
            check($sformatf("wb_count@%0d", cyc_n), 32'(wb_count), m_wb);
            if (!cv.rst) begin
                if (cv.clr) begin
                    m_hit  = 0;
                    m_miss = 0;
                    m_wb   = 0;
                end else begin
                    if (cv.ih && m_hit < CMAX)  m_hit++;
                    if (cv.im && m_miss < CMAX) m_miss++;
                    if (cv.iw && m_wb < CMAX)   m_wb++;
                end
            end
        end
    end

    function automatic vec_t idle_v();
        vec_t v;
        v = '0;
        v.exp[E_CR] = 1'b1;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        upstream_read   = v.ur;
        upstream_write  = v.uw;
        downstream_resp = v.dresp;
        counter_clear   = v.clr;
        rst             = v.rst;
        req_tag         = v.tag;
        exp_q.push_back(v);
    endtask

    // Builds the cycle-by-cycle trace of one request from the protocol rules.
    task automatic run_req(input logic wr, input logic [15:0] tag, input int n_fill,
                           input int m_wb_cyc, input logic clr, input int abort_at);
        vec_t rq;
        vec_t v;
        logic h;
        logic vd;
        rq     = idle_v();
        rq.ur  = !wr;
        rq.uw  = wr;
        rq.tag = tag;
        apply(rq);
        #1;
        h  = dp_hit;
        vd = dp_valid & dp_dirty;
        v     = rq;
        v.clr = clr;
        if (h) begin
            v.exp[E_UR]  = 1'b1;
            v.exp[E_LRU] = 1'b1;
            v.exp[E_LE]  = wr;
            v.exp[E_ND]  = wr;
            v.ih         = 1'b1;
            apply(v);
            return;
        end
        v.exp[E_WB] = vd;
        v.im        = 1'b1;
        apply(v);
        if (vd) begin
            for (int k = 0; k < m_wb_cyc; k++) begin
                v = rq;
                v.exp = '0;
                v.exp[E_SEL] = 1'b1;
                v.exp[E_DW]  = 1'b1;
                if (k == m_wb_cyc - 1) begin
                    v.dresp = 1'b1;
                    v.iw    = 1'b1;
                end
                apply(v);
            end
        end
        for (int k = 0; k < n_fill; k++) begin
            if (k == abort_at) begin
                v = idle_v();
                v.rst = 1'b1;
                apply(v);
                apply(idle_v());
                return;
            end
            v = rq;
            v.exp = '0;
            v.exp[E_DR] = 1'b1;
            if (k == n_fill - 1) begin
                v.dresp     = 1'b1;
                v.exp[E_LE] = 1'b1;
            end
            apply(v);
        end
        apply(rq);
        v = rq;
        v.exp[E_UR]  = 1'b1;
        v.exp[E_LRU] = 1'b1;
        v.exp[E_LE]  = wr;
        v.exp[E_ND]  = wr;
        apply(v);
    endtask

    task automatic settle();
        apply(idle_v());
        @(negedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        v = idle_v();
        v.rst = 1'b1;
        apply(v);
        apply(v);
        apply(idle_v());
        v = idle_v();
        v.dresp = 1'b1;
        apply(v);
        settle();
        check("pin_reset_hits", 32'(hit_count), 0);

        run_req(1'b0, 16'h100, 5, 0, 1'b0, -1);
        settle();
        check("pin_t1_miss", 32'(miss_count), 1);
        check("pin_t1_hit", 32'(hit_count), 0);

        run_req(1'b0, 16'h100, 0, 0, 1'b0, -1);
        settle();
        check("pin_t2_hit", 32'(hit_count), 1);

        run_req(1'b1, 16'h100, 0, 0, 1'b0, -1);

        run_req(1'b0, 16'h200, 3, 0, 1'b0, -1);
        run_req(1'b1, 16'h300, 2, 0, 1'b0, -1);
        run_req(1'b0, 16'h400, 1, 0, 1'b0, -1);
        run_req(1'b0, 16'h500, 2, 4, 1'b0, -1);
        settle();
        check("pin_t4_wb", 32'(wb_count), 1);
        check("pin_t4_miss", 32'(miss_count), 5);

        run_req(1'b0, 16'h600, 4, 3, 1'b0, 2);
        settle();
        check("pin_t5_miss", 32'(miss_count), 0);
        check("pin_t5_wb", 32'(wb_count), 0);

        for (int i = 0; i < 15; i++) run_req(1'b0, 16'h500, 0, 0, 1'b0, -1);
        settle();
        check("pin_t6_full", 32'(hit_count), 15);
        run_req(1'b0, 16'h500, 0, 0, 1'b0, -1);
        settle();
        check("pin_t6_sat", 32'(hit_count), 15);
        run_req(1'b0, 16'h500, 0, 0, 1'b1, -1);
        settle();
        check("pin_t6_clear", 32'(hit_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
